// File: rtl/id_ex_skid_if.sv
// Decode/execute payload bundle: valid/ready handshake plus the decoded fields.
// The producer uses the master modport and the consumer uses the slave modport.
interface id_ex_skid_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               valid;
    logic               ready;
    logic               mem_rd_flag;
    logic [XLEN-1:0]    ins;
    logic [XLEN-1:0]    ins_addr;
    logic [XLEN-1:0]    reg1_rd_data;
    logic [XLEN-1:0]    reg2_rd_data;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    csr_rd_data;
    logic [XLEN-1:0]    csr_rw_addr;
    logic [XLEN-1:0]    csr_zimm;
    logic [RADDR_W-1:0] reg_wr_addr;

    modport master (
        output valid, mem_rd_flag, ins, ins_addr, reg1_rd_data, reg2_rd_data,
               imm, csr_rd_data, csr_rw_addr, csr_zimm, reg_wr_addr,
        input  ready
    );

    modport slave (
        input  valid, mem_rd_flag, ins, ins_addr, reg1_rd_data, reg2_rd_data,
               imm, csr_rd_data, csr_rw_addr, csr_zimm, reg_wr_addr,
        output ready
    );
endinterface

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a two-entry skid buffer, flush-to-bubble,
// and a registered load read request that gates release of loads to EX.
module id_ex_skid #(
    parameter int              XLEN      = 32,
    parameter int              RADDR_W   = 5,
    parameter int              HOLD_W    = 3,
    parameter int              FLUSH_LVL = 3,
    parameter logic [XLEN-1:0] NOP_INS   = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HOLD_W-1:0] hold_flag_i,
    id_ex_skid_if.slave       id_i,
    id_ex_skid_if.master      ex_o,
    output logic              mem_rd_rib_req_o,
    output logic [XLEN-1:0]   mem_rd_addr_o,
    input  logic              mem_rd_gnt_i
);

    typedef struct packed {
        logic [XLEN-1:0]    ins;
        logic [XLEN-1:0]    ins_addr;
        logic [XLEN-1:0]    reg1;
        logic [XLEN-1:0]    reg2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    csr_rd;
        logic [XLEN-1:0]    csr_rw_addr;
        logic [XLEN-1:0]    csr_zimm;
        logic [RADDR_W-1:0] rd;
    } payload_t;

    typedef struct packed {
        payload_t        pl;
        logic            is_load;
        logic [XLEN-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    localparam logic [HOLD_W-1:0] FLUSH_THR = HOLD_W'(FLUSH_LVL);

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, in_entry;
    logic   main_done_q, main_done_d;
    logic   main_valid, id_ready, ex_valid, ld_req;
    logic   flush, accept, issue;

    // Effective address wraps modulo 2^XLEN, as a two's-complement adder does.
    function automatic logic [XLEN-1:0] load_addr(input logic signed [XLEN-1:0] base,
                                                  input logic signed [XLEN-1:0] ofs);
        logic signed [XLEN-1:0] sum;
        sum = base + ofs;
        return sum;
    endfunction

    always_comb begin
        in_entry.pl.ins         = id_i.ins;
        in_entry.pl.ins_addr    = id_i.ins_addr;
        in_entry.pl.reg1        = id_i.reg1_rd_data;
        in_entry.pl.reg2        = id_i.reg2_rd_data;
        in_entry.pl.imm         = id_i.imm;
        in_entry.pl.csr_rd      = id_i.csr_rd_data;
        in_entry.pl.csr_rw_addr = id_i.csr_rw_addr;
        in_entry.pl.csr_zimm    = id_i.csr_zimm;
        in_entry.pl.rd          = id_i.reg_wr_addr;
        in_entry.is_load        = id_i.mem_rd_flag;
        in_entry.addr           = load_addr(id_i.reg1_rd_data, id_i.imm);
    end

    assign flush  = (hold_flag_i >= FLUSH_THR);
    assign accept = id_i.valid & id_ready;
    assign issue  = ex_valid & ex_o.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_done_q <= main_done_d;
        end
    end

    // Payload storage carries no reset: it is only observed while its state says valid.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        main_done_d = main_done_q;
        if (flush) begin
            state_d     = EMPTY;
            main_done_d = 1'b0;
        end else begin
            if (ld_req && mem_rd_gnt_i) main_done_d = 1'b1;
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d     = ONE;
                    main_d      = in_entry;
                    main_done_d = 1'b0;
                end
                ONE: begin
                    if (accept && issue) begin
                        main_d      = in_entry;
                        main_done_d = 1'b0;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (issue) begin
                    state_d     = ONE;
                    main_d      = skid_q;
                    main_done_d = 1'b0;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_valid       = (state_q != EMPTY);
        id_ready         = (state_q != TWO);
        ld_req           = main_valid & main_q.is_load & ~main_done_q;
        ex_valid         = main_valid & (~main_q.is_load | main_done_q);
        id_i.ready       = id_ready;
        ex_o.valid       = ex_valid;
        ex_o.mem_rd_flag = main_valid & main_q.is_load;
        ex_o.ins          = main_valid ? main_q.pl.ins         : NOP_INS;
        ex_o.ins_addr     = main_valid ? main_q.pl.ins_addr    : '0;
        ex_o.reg1_rd_data = main_valid ? main_q.pl.reg1        : '0;
        ex_o.reg2_rd_data = main_valid ? main_q.pl.reg2        : '0;
        ex_o.imm          = main_valid ? main_q.pl.imm         : '0;
        ex_o.csr_rd_data  = main_valid ? main_q.pl.csr_rd      : '0;
        ex_o.csr_rw_addr  = main_valid ? main_q.pl.csr_rw_addr : '0;
        ex_o.csr_zimm     = main_valid ? main_q.pl.csr_zimm    : '0;
        ex_o.reg_wr_addr  = main_valid ? main_q.pl.rd          : '0;
        mem_rd_rib_req_o = ld_req;
        mem_rd_addr_o    = ld_req ? main_q.addr : '0;
    end

endmodule
